// File: rtl/result_collector_pkg.sv
// Shared widths, FIFO entry layout and FSM encoding for the result collector.
package result_collector_pkg;

  localparam int unsigned ROW_W   = 10;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned ENTRY_W = ROW_W + 2 * DATA_W;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDrain   = 2'd2,
    StDone    = 2'd3
  } state_e;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
  } entry_t;

endpackage

// File: rtl/result_collector_if.sv
// Ready/valid result stream leaving the collector.
interface result_collector_if;
  import result_collector_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [ROW_W-1:0]  out_row;
  logic [DATA_W-1:0] out_data1;
  logic [DATA_W-1:0] out_data2;

  modport master (
    output out_valid,
    output out_row,
    output out_data1,
    output out_data2,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_row,
    input  out_data1,
    input  out_data2,
    output out_ready
  );

endinterface

// File: rtl/result_collector_sync_fifo.sv
// First-word-fall-through FIFO; pointers carry one extra bit to tell full from empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic             push_drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees the slot in the same cycle, so a push into a full FIFO is legal then.
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign push_drop = push && !do_push;

  // Head reads as zero when empty so stale storage never leaks out.
  assign pop_data = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/result_collector.sv
// Collects per-row multiply results into a FIFO and streams them out, tracking pass completion.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int unsigned NUM_ROWS   = 560,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              acc_valid,
  input  logic              acc_zero,
  input  logic [DATA_W-1:0] acc_data1,
  input  logic [DATA_W-1:0] acc_data2,
  result_collector_if.master out_if,
  output logic              done,
  output logic              overflow,
  output logic              proto_err
);

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d, row_inc;
  logic             overflow_q, overflow_d;
  logic             proto_err_q, proto_err_d;

  logic             strobe, push, pop, push_drop;
  logic             fifo_empty, fifo_full;
  entry_t           push_entry, head;
  logic [ENTRY_W-1:0] head_raw;

  assign strobe  = acc_valid | acc_zero;
  assign push    = (state_q == StCollect) && strobe;
  assign pop     = out_if.out_valid && out_if.out_ready;
  assign row_inc = row_q + 1'b1;

  // acc_valid wins when both strobes fire; acc_zero alone yields a zero row.
  assign push_entry.row   = row_q;
  assign push_entry.data1 = acc_valid ? acc_data1 : '0;
  assign push_entry.data2 = acc_valid ? acc_data2 : '0;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_raw),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .push_drop (push_drop)
  );

  assign head             = entry_t'(head_raw);
  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_row   = head.row;
  assign out_if.out_data1 = head.data1;
  assign out_if.out_data2 = head.data2;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    overflow_d  = overflow_q;
    proto_err_d = proto_err_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StCollect;
          row_d       = '0;
          overflow_d  = 1'b0;
          proto_err_d = 1'b0;
        end
      end
      StCollect: begin
        if (strobe) begin
          row_d = row_inc;
          if (acc_valid && acc_zero) proto_err_d = 1'b1;
          if (push_drop)             overflow_d  = 1'b1;
          if (row_inc == ROW_W'(NUM_ROWS)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (fifo_empty) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      row_q       <= '0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign done      = (state_q == StDone);
  assign overflow  = overflow_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench: dut_a (4 rows) covers pass flow, flags and reset; dut_b (20 rows) covers FIFO fill.
module tb_result_collector;
  import result_collector_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_a, start_b;
  logic              acc_valid, acc_zero;
  logic [DATA_W-1:0] acc_data1, acc_data2;
  logic              done_a, overflow_a, proto_err_a;
  logic              done_b, overflow_b, proto_err_b;

  int checks = 0;
  int errors = 0;

  result_collector_if if_a ();
  result_collector_if if_b ();

  result_collector #(.NUM_ROWS(4), .FIFO_DEPTH(16)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .start     (start_a),
    .acc_valid (acc_valid),
    .acc_zero  (acc_zero),
    .acc_data1 (acc_data1),
    .acc_data2 (acc_data2),
    .out_if    (if_a),
    .done      (done_a),
    .overflow  (overflow_a),
    .proto_err (proto_err_a)
  );

  result_collector #(.NUM_ROWS(20), .FIFO_DEPTH(16)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .start     (start_b),
    .acc_valid (acc_valid),
    .acc_zero  (acc_zero),
    .acc_data1 (acc_data1),
    .acc_data2 (acc_data2),
    .out_if    (if_b),
    .done      (done_b),
    .overflow  (overflow_b),
    .proto_err (proto_err_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    acc_valid = 1'b0;
    acc_zero = 1'b0;
    acc_data1 = '0;
    acc_data2 = '0;
    if_a.out_ready = 1'b1;
    if_b.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", if_a.out_valid, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_ovf", overflow_a, 1'b0);
    chk("rst_perr", proto_err_a, 1'b0);
    chk("rst_row", if_a.out_row, 10'd0);
    chk("rst_d1", if_a.out_data1, 64'd0);
    chk("rst_d2", if_a.out_data2, 64'd0);
    rst = 1'b1;
    tick();

    // Pass 1: mixed valid/zero rows, consumer always ready.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    acc_valid = 1'b1; acc_data1 = 64'd5; acc_data2 = 64'd7;
    tick();
    chk("p1_v0", if_a.out_valid, 1'b1);
    chk("p1_r0", {if_a.out_row, if_a.out_data1, if_a.out_data2}, {10'd0, 64'd5, 64'd7});
    acc_valid = 1'b0; acc_zero = 1'b1;
    tick();
    chk("p1_r1", {if_a.out_row, if_a.out_data1, if_a.out_data2}, {10'd1, 64'd0, 64'd0});
    acc_zero = 1'b0; acc_valid = 1'b1; acc_data1 = 64'd9; acc_data2 = 64'd11;
    tick();
    chk("p1_r2", {if_a.out_row, if_a.out_data1, if_a.out_data2}, {10'd2, 64'd9, 64'd11});
    acc_valid = 1'b0; acc_zero = 1'b1;
    tick();
    chk("p1_r3", {if_a.out_row, if_a.out_data1, if_a.out_data2}, {10'd3, 64'd0, 64'd0});
    // Strobe during DRAIN must be ignored.
    acc_zero = 1'b0; acc_valid = 1'b1; acc_data1 = 64'hEE; acc_data2 = 64'hEE;
    tick();
    chk("drain_empty", if_a.out_valid, 1'b0);
    chk("drain_notdone", done_a, 1'b0);
    acc_valid = 1'b0;
    tick();
    chk("p1_done", done_a, 1'b1);
    chk("drain_ignored", if_a.out_valid, 1'b0);
    tick();
    chk("done_hold", done_a, 1'b1);

    // Pass 2 from DONE: both strobes at row 0.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("p2_leave_done", done_a, 1'b0);
    acc_valid = 1'b1; acc_zero = 1'b1; acc_data1 = 64'd3; acc_data2 = 64'd4;
    tick();
    chk("both_perr", proto_err_a, 1'b1);
    chk("both_entry", {if_a.out_valid, if_a.out_row, if_a.out_data1, if_a.out_data2},
        {1'b1, 10'd0, 64'd3, 64'd4});
    acc_valid = 1'b0; acc_zero = 1'b0;
    tick();
    chk("both_single", if_a.out_valid, 1'b0);
    acc_zero = 1'b1;
    tick(); tick(); tick();
    acc_zero = 1'b0;
    tick(); tick();
    chk("p2_done", done_a, 1'b1);
    chk("perr_sticky", proto_err_a, 1'b1);

    // Pass 3 from DONE clears flags, then reset mid-pass.
    if_a.out_ready = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("p3_perr_clr", proto_err_a, 1'b0);
    chk("p3_done_clr", done_a, 1'b0);
    acc_valid = 1'b1; acc_data1 = 64'd1; acc_data2 = 64'd2;
    tick();
    acc_data1 = 64'd3; acc_data2 = 64'd4;
    tick();
    acc_valid = 1'b0;
    chk("p3_head_held", {if_a.out_valid, if_a.out_row, if_a.out_data1}, {1'b1, 10'd0, 64'd1});
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", if_a.out_valid, 1'b0);
    chk("mid_rst_row", if_a.out_row, 10'd0);
    chk("mid_rst_done", done_a, 1'b0);
    tick();
    rst = 1'b1;
    if_a.out_ready = 1'b1;
    acc_valid = 1'b1; acc_data1 = 64'hAA; acc_data2 = 64'hBB;
    tick();
    chk("idle_ignores", if_a.out_valid, 1'b0);
    acc_valid = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0;
    chk("restart_row0", {if_a.out_valid, if_a.out_row, if_a.out_data1, if_a.out_data2},
        {1'b1, 10'd0, 64'hAA, 64'hBB});
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // dut_b: 17 strobes into a 16-deep FIFO with a stalled consumer.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) chk("ovf_before_17", overflow_b, 1'b0);
      acc_valid = 1'b1; acc_data1 = 64'(i); acc_data2 = 64'(i + 100);
      tick();
    end
    acc_valid = 1'b0;
    chk("ovf_set", overflow_b, 1'b1);
    chk("ovf_head", if_b.out_row, 10'd0);
    if_b.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("ovf_drain%0d", k),
          {if_b.out_valid, if_b.out_row, if_b.out_data1, if_b.out_data2},
          {1'b1, 10'(k), 64'(k), 64'(k + 100)});
      tick();
    end
    chk("ovf_17_absent", if_b.out_valid, 1'b0);

    // dut_b: push and pop together while full.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    if_b.out_ready = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 16; i++) begin
      acc_valid = 1'b1; acc_data1 = 64'(i); acc_data2 = 64'(i + 100);
      tick();
    end
    chk("full_no_ovf", overflow_b, 1'b0);
    if_b.out_ready = 1'b1;
    acc_data1 = 64'd16; acc_data2 = 64'd116;
    tick();
    acc_valid = 1'b0;
    chk("pp_no_ovf", overflow_b, 1'b0);
    for (int k = 1; k < 17; k++) begin
      chk($sformatf("pp_order%0d", k),
          {if_b.out_valid, if_b.out_row, if_b.out_data1, if_b.out_data2},
          {1'b1, 10'(k), 64'(k), 64'(k + 100)});
      tick();
    end
    chk("pp_empty", if_b.out_valid, 1'b0);
    chk("pp_ovf_final", overflow_b, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 560, meaning result rows per multiply pass.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16 (power of two), meaning entries in the output buffer.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a collection pass.
REQ-006 SHALL have port acc_valid  input  1  upstream row-complete strobe; acc_data1/acc_data2 are valid this cycle.
REQ-007 SHALL have port acc_zero  input  1  upstream empty-row strobe; the row result is zero.
REQ-008 SHALL have ports acc_data1 and acc_data2, each input, 64 bits: the two accumulated column results.
REQ-009 SHALL have port out_valid  output  1  head entry available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the head entry.
REQ-011 SHALL have port out_row  output  10  row index of the head entry.
REQ-012 SHALL have ports out_data1 and out_data2, each output, 64 bits: head entry results.
REQ-013 SHALL have port done  output  1  level signal: the pass is complete and drained.
REQ-014 SHALL have port overflow  output  1  sticky flag: a push was dropped.
REQ-015 SHALL have port proto_err  output  1  sticky flag: acc_valid and acc_zero were both high in the same cycle.

Function
REQ-016 SHALL implement FSM states IDLE, COLLECT, DRAIN, DONE.
REQ-017 SHALL go IDLE->COLLECT on start, clearing the row index, overflow and proto_err.
REQ-018 SHALL, in COLLECT, push one entry per acc_valid or acc_zero cycle and increment the row index by 1.
REQ-019 Entry SHALL be {row index, acc_data1, acc_data2} for acc_valid, and {row index, 64'h0, 64'h0} for acc_zero.
REQ-020 When acc_valid and acc_zero are high together, SHALL push the acc_valid entry only, increment once, and set proto_err.
REQ-021 SHALL go COLLECT->DRAIN on the cycle the row index is incremented to NUM_ROWS; strobes arriving after that SHALL be ignored.
REQ-022 SHALL go DRAIN->DONE when the FIFO is empty; done=1 only in DONE.
REQ-023 SHALL go DONE->COLLECT on start (new pass, counters cleared); DONE SHALL otherwise hold.
REQ-024 SHALL ignore acc_valid, acc_zero and start in states where they are not listed above.
REQ-025 FIFO SHALL be first-word-fall-through; a push at edge N SHALL be visible as out_valid=1 with its data after edge N (1-cycle latency).
REQ-026 SHALL pop on a cycle where out_valid and out_ready are both high; out_row/out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 A push while full without a simultaneous pop SHALL be dropped and set overflow; the row index SHALL still increment.
REQ-028 A push and pop in the same cycle while full SHALL succeed with occupancy unchanged.
REQ-029 A push and pop in the same cycle while empty: the pushed entry SHALL appear next cycle.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with an extra bit used for full/empty disambiguation.

Reset
REQ-031 On rst=0, SHALL asynchronously go to IDLE with FIFO empty, row index 0, and out_valid=0, done=0, overflow=0, proto_err=0.
REQ-032 On rst=0, out_row, out_data1 and out_data2 SHALL be 0.
REQ-033 Reset asserted mid-pass SHALL discard all buffered entries; no output handshake occurs until the next start.

Structure
REQ-034 SHALL place ROW_W=10, DATA_W=64 and the FSM state encoding in a shared package.
REQ-035 SHALL instantiate one sub-module, sync_fifo, parameterised by width (ROW_W+2*DATA_W) and depth.

Verification
REQ-036 SHALL test NUM_ROWS=4 with out_ready=1: acc_valid rows 0,2 (data 5/7, 9/11) and acc_zero rows 1,3 -> outputs in order (0,5,7), (1,0,0), (2,9,11), (3,0,0); done=1 one cycle after the last pop.
REQ-037 SHALL test out_ready=0 with 17 strobes into FIFO_DEPTH=16 -> 16 entries held and overflow=1; the 17th entry is absent on drain.
REQ-038 SHALL test full FIFO with push and pop in the same cycle -> no overflow and ordering preserved.
REQ-039 SHALL test acc_valid and acc_zero together at row 0 with data 3/4 -> single entry (0,3,4) and proto_err=1.
REQ-040 SHALL test rst pulsed low after 2 of 4 rows -> out_valid=0 and IDLE immediately; a new start yields rows from 0.
REQ-041 SHALL test a strobe arriving in DRAIN -> ignored, and a start in DONE -> new pass with flags cleared.
